// File: rtl/axi3_wr_responder_if.sv
// AXI3 write-channel bundle: request fields driven by the master, response
// fields and BID driven by the slave.
interface axi3_wr_responder_if #(
    parameter int ID_W = 4
);
    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [3:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } req_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        logic       bvalid;
        logic [1:0] bresp;
    } resp_t;

    req_t            axi3_wr_req;
    resp_t           axi3_wr_resp;
    logic [ID_W-1:0] awid;
    logic [ID_W-1:0] wid;
    logic [ID_W-1:0] bid;

    modport slave (
        input  axi3_wr_req,
        input  awid,
        input  wid,
        output axi3_wr_resp,
        output bid
    );

    modport master (
        output axi3_wr_req,
        output awid,
        output wid,
        input  axi3_wr_resp,
        input  bid
    );
endinterface

// File: rtl/axi3_wr_responder.sv
// AXI3 write responder: accepts one AW, streams the W beats into a 32-bit
// word SRAM with byte enables, then returns a single B response.
module axi3_wr_responder #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ID_W      = 4,
    localparam int         AW        = $clog2(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    axi3_wr_responder_if.slave        axi3_wr_if,
    output logic                      mem_en,
    output logic [3:0]                mem_be,
    output logic [AW-1:0]             mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      busy
);

    localparam logic [1:0]  RESP_IDLE  = 2'd0;
    localparam logic [1:0]  RESP_DATA  = 2'd1;
    localparam logic [1:0]  RESP_BRESP = 2'd2;
    localparam logic [31:0] MEM_BYTES  = 32'(MEM_DEPTH * 4);
    localparam logic [1:0]  BURST_INCR = 2'b01;

    logic [1:0]      state_r;
    logic [1:0]      state_s;
    logic            rdy_r;
    logic [ID_W-1:0] id_r;
    logic [3:0]      len_r;
    logic [1:0]      burst_r;
    logic [AW-1:0]   idx_r;
    logic            err_r;
    logic [3:0]      beat_cnt_r;

    logic            awready_s;
    logic            wready_s;
    logic            bvalid_s;
    logic            aw_hs_s;
    logic            w_hs_s;
    logic            b_hs_s;
    logic [31:0]     off_s;
    logic            dec_err_s;
    logic            in_len_s;
    logic            beat_err_s;

    // rdy_r keeps awready low until the first clock after reset release
    assign awready_s = (state_r == RESP_IDLE) & rdy_r;
    assign wready_s  = (state_r == RESP_DATA);
    assign bvalid_s  = (state_r == RESP_BRESP);

    assign aw_hs_s = awready_s & axi3_wr_if.axi3_wr_req.awvalid;
    assign w_hs_s  = wready_s  & axi3_wr_if.axi3_wr_req.wvalid;
    assign b_hs_s  = bvalid_s  & axi3_wr_if.axi3_wr_req.bready;

    // Unsigned offset: an address below BASE_ADDR wraps high and fails the range test
    assign off_s     = axi3_wr_if.axi3_wr_req.awaddr - BASE_ADDR;
    assign dec_err_s = (axi3_wr_if.axi3_wr_req.awsize != 3'b010)
                     | axi3_wr_if.axi3_wr_req.awburst[1]
                     | (off_s >= MEM_BYTES)
                     | (axi3_wr_if.axi3_wr_req.awaddr[1:0] != 2'b00);

    assign in_len_s   = (beat_cnt_r <= len_r);
    assign beat_err_s = (axi3_wr_if.wid != id_r)
                      | ~in_len_s
                      | (axi3_wr_if.axi3_wr_req.wlast & (beat_cnt_r != len_r));

    // Next-state decode for the three-phase write transaction
    always_comb begin
        state_s = state_r;
        case (state_r)
            RESP_IDLE: begin
                if (aw_hs_s) state_s = RESP_DATA;
                else         state_s = RESP_IDLE;
            end
            RESP_DATA: begin
                if (w_hs_s & axi3_wr_if.axi3_wr_req.wlast) state_s = RESP_BRESP;
                else                                        state_s = RESP_DATA;
            end
            RESP_BRESP: begin
                if (b_hs_s) state_s = RESP_IDLE;
                else        state_s = RESP_BRESP;
            end
            default: state_s = RESP_IDLE;
        endcase
    end

    // State, captured AW attributes, beat counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RESP_IDLE;
            rdy_r      <= 1'b0;
            id_r       <= {ID_W{1'b0}};
            len_r      <= 4'd0;
            burst_r    <= 2'b00;
            idx_r      <= {AW{1'b0}};
            err_r      <= 1'b0;
            beat_cnt_r <= 4'd0;
        end else begin
            state_r <= state_s;
            rdy_r   <= 1'b1;
            if (aw_hs_s) begin
                id_r       <= axi3_wr_if.awid;
                len_r      <= axi3_wr_if.axi3_wr_req.awlen;
                burst_r    <= axi3_wr_if.axi3_wr_req.awburst;
                idx_r      <= off_s[AW+1:2];
                err_r      <= dec_err_s;
                beat_cnt_r <= 4'd0;
            end else if (w_hs_s) begin
                if (beat_err_s) err_r <= 1'b1;
                if (beat_cnt_r != 4'hF) beat_cnt_r <= beat_cnt_r + 4'd1;
                // Index wraps naturally at MEM_DEPTH since it is exactly AW bits
                if (burst_r == BURST_INCR) idx_r <= idx_r + {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Write strobe follows the W handshake in the same cycle; reset drops it via state
    assign mem_en    = w_hs_s & ~err_r & in_len_s;
    assign mem_be    = mem_en ? axi3_wr_if.axi3_wr_req.wstrb : 4'h0;
    assign mem_wdata = mem_en ? axi3_wr_if.axi3_wr_req.wdata : 32'h0000_0000;
    assign mem_addr  = idx_r;
    assign busy      = (state_r != RESP_IDLE);

    assign axi3_wr_if.axi3_wr_resp.awready = awready_s;
    assign axi3_wr_if.axi3_wr_resp.wready  = wready_s;
    assign axi3_wr_if.axi3_wr_resp.bvalid  = bvalid_s;
    assign axi3_wr_if.axi3_wr_resp.bresp   = (bvalid_s & err_r) ? 2'b10 : 2'b00;
    assign axi3_wr_if.bid                  = bvalid_s ? id_r : {ID_W{1'b0}};

endmodule
